// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Takes pending keycodes from the PS/2 receiver, acknowledges each with a
// one-cycle kb_clear strobe, and queues make/break events in a small FIFO.
// Error codes (8'hFF) are counted and never queued.
module ps2_key_event_ctrl #(
    parameter int DEPTH         = 8,
    parameter int CLEAR_TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     kb_irq,
    input  logic [7:0]               kb_keycode,
    output logic                     kb_clear,
    output logic                     evt_valid,
    output logic [6:0]               evt_code,
    output logic                     evt_break,
    input  logic                     evt_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [7:0]               error_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (CLEAR_TIMEOUT > 1) ? $clog2(CLEAR_TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CLEAR    = 2'd1;
    localparam logic [1:0] S_WAIT_LOW = 2'd2;

    localparam logic [7:0]    ERR_CODE = 8'hFF;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLEAR_TIMEOUT - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [1:0]    state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic          first_q, first_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_q, push_d;
    logic          err_inc;
    logic [7:0]    error_count_q;
    logic          overflow_q;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          full, pop, do_write, drop;

    // Handshake FSM: latch a pending code, strobe kb_clear, wait for irq to drop.
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        push_d  = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (kb_irq) begin
                    code_d  = kb_keycode;
                    first_d = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Only the first ack of a code queues or counts it; retries just re-strobe.
                if (first_q) begin
                    if (code_q == ERR_CODE) err_inc = 1'b1;
                    else                    push_d  = 1'b1;
                end
                first_d = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!kb_irq)                state_d = S_IDLE;
                else if (cnt_q == CNT_LAST) state_d = S_CLEAR;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, push request and error counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            code_q        <= '0;
            first_q       <= 1'b0;
            cnt_q         <= '0;
            push_q        <= 1'b0;
            error_count_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            push_q  <= push_d;
            if (err_inc && error_count_q != 8'hFF) error_count_q <= error_count_q + 1'b1;
        end
    end

    // FIFO control: flush overrides everything; a full FIFO still accepts a push when popping.
    always_comb begin
        full     = (level_q == LVL_FULL);
        pop      = (level_q != '0) && evt_ready && !flush;
        do_write = push_q && !flush && (!full || pop);
        drop     = push_q && !flush && full && !pop;
        if (flush) level_d = '0;
        else       level_d = level_q + LW'(do_write) - LW'(pop);
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q <= level_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop)                overflow_q <= 1'b1;
            else if (clear_overflow) overflow_q <= 1'b0;
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array is deliberately not reset; occupancy is tracked by
    // the reset pointers and level, so stale entries are never visible.
    always_ff @(posedge clock) begin
        if (do_write) mem[wr_ptr_q] <= code_q;
    end

    assign kb_clear    = (state_q == S_CLEAR);
    assign evt_valid   = (level_q != '0);
    assign evt_code    = mem[rd_ptr_q][6:0];
    assign evt_break   = mem[rd_ptr_q][7];
    assign fifo_level  = level_q;
    assign overflow    = overflow_q;
    assign error_count = error_count_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Self-checking bench for ps2_key_event_ctrl: a receiver model drives keycodes,
// a scoreboard queue holds expected events and a monitor compares each pop.
module tb_ps2_key_event_ctrl;

    localparam int DEPTH         = 8;
    localparam int CLEAR_TIMEOUT = 16;
    localparam int LW            = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          kb_irq = 1'b0;
    logic [7:0]    kb_keycode = 8'h00;
    logic          kb_clear;
    logic          evt_valid;
    logic [6:0]    evt_code;
    logic          evt_break;
    logic          evt_ready = 1'b0;
    logic          flush = 1'b0;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          clear_overflow = 1'b0;
    logic [7:0]    error_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    ps2_key_event_ctrl #(.DEPTH(DEPTH), .CLEAR_TIMEOUT(CLEAR_TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .kb_irq(kb_irq), .kb_keycode(kb_keycode),
        .kb_clear(kb_clear), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_break(evt_break), .evt_ready(evt_ready), .flush(flush),
        .fifo_level(fifo_level), .overflow(overflow), .clear_overflow(clear_overflow),
        .error_count(error_count)
    );

    always #5 clock = ~clock;

    // Monitor: every accepted head must match the oldest expected event.
    always @(negedge clock) begin
        if (reset_n && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            logic [7:0] exp;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h, scoreboard empty", {evt_break, evt_code});
            end else begin
                exp = sb_q.pop_front();
                if ({evt_break, evt_code} !== exp) begin
                    errors++;
                    $display("FAIL pop_data: got %h, expected %h", {evt_break, evt_code}, exp);
                end
            end
        end
    end

    // Receiver model: raise irq with a code, wait for the ack, then drop irq.
    // Returns just after the ack edge; the push lands on the following edge.
    task automatic send_code(input logic [7:0] code, input bit expect_push);
        int n;
        @(posedge clock); #1;
        kb_irq = 1'b1;
        kb_keycode = code;
        if (expect_push) sb_q.push_back(code);
        n = 0;
        @(negedge clock);
        while (kb_clear !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (kb_clear !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout: kb_clear=%b, expected 1 for code %h", kb_clear, code);
        end
        @(posedge clock); #1;
        kb_irq = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        evt_ready = 1'b1;
        while (evt_valid === 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: evt_valid=%b left=%0d, expected 0 and 0", evt_valid, sb_q.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if (evt_valid !== 1'b0 || fifo_level !== '0 || kb_clear !== 1'b0 ||
            overflow !== 1'b0 || error_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: valid=%b level=%0d clear=%b ovf=%b err=%0d, expected all 0",
                     evt_valid, fifo_level, kb_clear, overflow, error_count);
        end
    endtask

    task automatic test_single();
        send_code(8'h0A, 1'b1);
        @(negedge clock);
        checks++;
        if (kb_clear !== 1'b0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_timing: clear=%b valid=%b, expected 0 and 0", kb_clear, evt_valid);
        end
        @(posedge clock); #1;
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 7'h0A || evt_break !== 1'b0 || fifo_level !== LW'(1)) begin
            errors++;
            $display("FAIL single_head: valid=%b code=%h brk=%b level=%0d, expected 1 0a 0 1",
                     evt_valid, evt_code, evt_break, fifo_level);
        end
        drain();
    endtask

    task automatic test_order();
        send_code(8'h01, 1'b1);
        send_code(8'h81, 1'b1);
        @(posedge clock); #1;
        checks++;
        if (fifo_level !== LW'(2) || evt_code !== 7'h01 || evt_break !== 1'b0) begin
            errors++;
            $display("FAIL order_level: level=%0d code=%h brk=%b, expected 2 01 0",
                     fifo_level, evt_code, evt_break);
        end
        drain();
    endtask

    task automatic test_errors();
        for (int i = 0; i < 300; i++) begin
            send_code(8'hFF, 1'b0);
            if (i == 4) begin
                checks++;
                if (error_count !== 8'd5) begin
                    errors++;
                    $display("FAIL err_count_5: got %0d, expected 5", error_count);
                end
            end
        end
        @(posedge clock); #1;
        checks++;
        if (error_count !== 8'hFF || evt_valid !== 1'b0 || fifo_level !== '0) begin
            errors++;
            $display("FAIL err_saturate: err=%0d valid=%b level=%0d, expected 255 0 0",
                     error_count, evt_valid, fifo_level);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= DEPTH; i++) send_code(8'h10 + 8'(i), i < DEPTH);
        @(posedge clock); #1;
        checks++;
        if (fifo_level !== LW'(DEPTH) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: level=%0d ovf=%b, expected %0d 1", fifo_level, overflow, DEPTH);
        end
        clear_overflow = 1'b1;
        @(posedge clock); #1;
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, expected 0", overflow);
        end
        // Full FIFO: pop on exactly the edge the new code is pushed.
        send_code(8'h20, 1'b1);
        evt_ready = 1'b1;
        @(posedge clock); #1;
        evt_ready = 1'b0;
        checks++;
        if (fifo_level !== LW'(DEPTH) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: level=%0d ovf=%b, expected %0d 0", fifo_level, overflow, DEPTH);
        end
        drain();
    endtask

    task automatic test_retry();
        int n, cyc, last, pulses;
        @(posedge clock); #1;
        kb_irq = 1'b1;
        kb_keycode = 8'h33;
        sb_q.push_back(8'h33);
        n = 0;
        @(negedge clock);
        while (kb_clear !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        last = 0;
        pulses = (kb_clear === 1'b1) ? 1 : 0;
        for (cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clock);
            if (kb_clear === 1'b1) begin
                checks++;
                if (cyc - last != CLEAR_TIMEOUT + 1) begin
                    errors++;
                    $display("FAIL retry_period: got %0d cycles, expected %0d", cyc - last, CLEAR_TIMEOUT + 1);
                end
                last = cyc;
                pulses++;
            end
        end
        @(posedge clock); #1;
        kb_irq = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (pulses != 4 || fifo_level !== LW'(1)) begin
            errors++;
            $display("FAIL retry_count: pulses=%0d level=%0d, expected 4 1", pulses, fifo_level);
        end
        drain();
    endtask

    task automatic test_flush();
        send_code(8'h41, 1'b1);
        send_code(8'h42, 1'b1);
        send_code(8'h44, 1'b0);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        sb_q.delete();
        checks++;
        if (fifo_level !== '0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_push: level=%0d valid=%b, expected 0 0", fifo_level, evt_valid);
        end
        send_code(8'hC5, 1'b1);
        @(posedge clock); #1;
        checks++;
        if (fifo_level !== LW'(1) || evt_code !== 7'h45 || evt_break !== 1'b1) begin
            errors++;
            $display("FAIL after_flush: level=%0d code=%h brk=%b, expected 1 45 1",
                     fifo_level, evt_code, evt_break);
        end
        drain();
    endtask

    task automatic test_reset_midway();
        int n;
        send_code(8'h51, 1'b1);
        send_code(8'h52, 1'b1);
        @(posedge clock); #1;
        kb_irq = 1'b1;
        kb_keycode = 8'h53;
        n = 0;
        @(negedge clock);
        while (kb_clear !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || fifo_level !== '0 || kb_clear !== 1'b0 ||
            overflow !== 1'b0 || error_count !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: valid=%b level=%0d clear=%b ovf=%b err=%0d, expected all 0",
                     evt_valid, fifo_level, kb_clear, overflow, error_count);
        end
        kb_irq = 1'b0;
        sb_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        send_code(8'h60, 1'b1);
        @(posedge clock); #1;
        checks++;
        if (fifo_level !== LW'(1) || evt_code !== 7'h60) begin
            errors++;
            $display("FAIL post_reset: level=%0d code=%h, expected 1 60", fifo_level, evt_code);
        end
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        reset_n = 1'b1;
        test_single();
        test_order();
        test_errors();
        test_overflow();
        test_retry();
        test_flush();
        test_reset_midway();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected events never popped, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
